// File: rtl/lsb_param_if.sv
// Memory-controller bus of the load/store buffer.
// Handshake: the buffer raises mc_en with mc_wr/mc_addr/mc_len/mc_w_data and keeps
// all of them stable until the controller pulses mc_done for one cycle; on that
// cycle mc_r_data carries load data (zero-extended). mc_en drops on the next edge.
interface lsb_param_if;
    logic        mc_en;
    logic        mc_wr;
    logic [31:0] mc_addr;
    logic [2:0]  mc_len;
    logic [31:0] mc_w_data;
    logic        mc_done;
    logic [31:0] mc_r_data;

    modport master (
        output mc_en, mc_wr, mc_addr, mc_len, mc_w_data,
        input  mc_done, mc_r_data
    );

    modport slave (
        input  mc_en, mc_wr, mc_addr, mc_len, mc_w_data,
        output mc_done, mc_r_data
    );
endinterface

// File: rtl/lsb_param.sv
// Parametrised in-order load/store buffer. Only the head entry executes: loads run
// speculatively (MMIO loads only at ROB head), stores only once committed. Operands
// wake up from two CDB ports. Rollback keeps the committed store prefix.
// Optional macro LSB_PARAM_STAT_EN adds saturating load/store/stall counters.
module lsb_param #(
    parameter int          DEPTH      = 16,
    parameter int          ROB_W      = 4,
    parameter logic [1:0]  IO_MASK_HI = 2'b11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  rollback,
    input  logic                  issue_valid,
    input  logic [ROB_W-1:0]      issue_rob_pos,
    input  logic                  issue_is_store,
    input  logic [2:0]            issue_funct3,
    input  logic [31:0]           issue_rs1_val,
    input  logic [31:0]           issue_rs2_val,
    input  logic [ROB_W:0]        issue_rs1_tag,
    input  logic [ROB_W:0]        issue_rs2_tag,
    input  logic [31:0]           issue_imm,
    input  logic                  cdb0_valid,
    input  logic [ROB_W-1:0]      cdb0_rob_pos,
    input  logic [31:0]           cdb0_val,
    input  logic                  cdb1_valid,
    input  logic [ROB_W-1:0]      cdb1_rob_pos,
    input  logic [31:0]           cdb1_val,
    input  logic                  commit_store,
    input  logic [ROB_W-1:0]      commit_rob_pos,
    input  logic [ROB_W-1:0]      head_rob_pos,
    lsb_param_if.master           mc,
    output logic                  result_valid,
    output logic [ROB_W-1:0]      result_rob_pos,
    output logic [31:0]           result_val,
    output logic                  nxt_full,
    output logic [$clog2(DEPTH):0] count,
    output logic [1:0]            dbg_state
`ifdef LSB_PARAM_STAT_EN
    ,
    output logic [31:0]           stat_loads,
    output logic [31:0]           stat_stores,
    output logic [31:0]           stat_stall
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // ORPHAN: a rolled-back load still owns the bus until mc_done, result discarded.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ORPHAN = 2'd2} state_t;
    state_t state, state_next;

    logic [PW-1:0]    head, tail;
    logic [CW-1:0]    committed_cnt, count_next;

    logic             valid_q     [DEPTH];
    logic             committed_q [DEPTH];
    logic             is_store_q  [DEPTH];
    logic [2:0]       funct3_q    [DEPTH];
    logic [ROB_W-1:0] rob_q       [DEPTH];
    logic             rs1_pend_q  [DEPTH];
    logic [ROB_W-1:0] rs1_pos_q   [DEPTH];
    logic [31:0]      rs1_val_q   [DEPTH];
    logic             rs2_pend_q  [DEPTH];
    logic [ROB_W-1:0] rs2_pos_q   [DEPTH];
    logic [31:0]      rs2_val_q   [DEPTH];
    logic [31:0]      imm_q       [DEPTH];

    logic [31:0] head_addr;
    logic        head_mmio, head_is_store, head_ready;
    logic        launch, pop, load_result, issue_acc;

    // Operand capture from the CDBs; cdb1 is applied last so it wins on a tie.
    function automatic logic [32:0] snoop(input logic pend, input logic [ROB_W-1:0] pos,
                                          input logic [31:0] val);
        logic [32:0] r;
        r = {pend, val};
        if (pend && cdb0_valid && cdb0_rob_pos == pos) r = {1'b0, cdb0_val};
        if (pend && cdb1_valid && cdb1_rob_pos == pos) r = {1'b0, cdb1_val};
        return r;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return {{24{d[7]}}, d[7:0]};
            3'b001:  return {{16{d[15]}}, d[15:0]};
            3'b100:  return {24'h0, d[7:0]};
            3'b101:  return {16'h0, d[15:0]};
            default: return d;
        endcase
    endfunction

    // Head-entry decode: effective address, MMIO test and readiness to go to memory.
    always_comb begin
        head_addr     = rs1_val_q[head] + imm_q[head];
        head_mmio     = (head_addr[17:16] == IO_MASK_HI);
        head_is_store = is_store_q[head];
        head_ready    = 1'b0;
        if (count != '0 && valid_q[head] && !rs1_pend_q[head] && !rs2_pend_q[head] && !rollback) begin
            if (head_is_store) head_ready = committed_q[head];
            else               head_ready = !head_mmio || (rob_q[head] == head_rob_pos);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)      state <= S_IDLE;
        else if (rdy) state <= state_next;
    end

    // FSM next state and per-cycle control strobes.
    always_comb begin
        state_next  = state;
        launch      = 1'b0;
        pop         = 1'b0;
        load_result = 1'b0;
        case (state)
            S_IDLE: begin
                if (head_ready) begin
                    launch     = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mc.mc_done) begin
                    state_next = S_IDLE;
                    if (head_is_store) begin
                        pop = 1'b1;
                    end else if (!rollback) begin
                        pop         = 1'b1;
                        load_result = 1'b1;
                    end
                end else if (rollback && !head_is_store) begin
                    state_next = S_ORPHAN;
                end
            end
            S_ORPHAN: begin
                if (mc.mc_done) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Occupancy bookkeeping; a pop frees the slot an issue may refill in the same cycle.
    always_comb begin
        issue_acc  = issue_valid && !rollback && ((count != DEPTH_C) || pop);
        count_next = count;
        if (rdy) begin
            if (rollback) count_next = committed_cnt - CW'(pop);
            else          count_next = count + CW'(issue_acc) - CW'(pop);
        end
        nxt_full  = (count_next == DEPTH_C);
        dbg_state = state;
    end

    // Queue storage: wakeup, commit, rollback, pop and enqueue.
    always_ff @(posedge clk) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            committed_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]     <= 1'b0;
                committed_q[i] <= 1'b0;
            end
        end else if (rdy) begin
            count <= count_next;
            if (rollback) begin
                for (int i = 0; i < DEPTH; i++)
                    if (!committed_q[i]) valid_q[i] <= 1'b0;
                tail          <= head + committed_cnt[PW-1:0];
                committed_cnt <= committed_cnt - CW'(pop);
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid_q[i]) begin
                        {rs1_pend_q[i], rs1_val_q[i]} <= snoop(rs1_pend_q[i], rs1_pos_q[i], rs1_val_q[i]);
                        {rs2_pend_q[i], rs2_val_q[i]} <= snoop(rs2_pend_q[i], rs2_pos_q[i], rs2_val_q[i]);
                    end
                    if (commit_store && valid_q[i] && is_store_q[i] && !committed_q[i] &&
                        rob_q[i] == commit_rob_pos)
                        committed_q[i] <= 1'b1;
                end
                committed_cnt <= committed_cnt + CW'(commit_store) - CW'(pop && head_is_store);
            end
            if (pop) begin
                head                 <= head + PW'(1);
                valid_q[head]        <= 1'b0;
                committed_q[head]    <= 1'b0;
            end
            if (issue_acc) begin
                valid_q[tail]        <= 1'b1;
                committed_q[tail]    <= 1'b0;
                is_store_q[tail]     <= issue_is_store;
                funct3_q[tail]       <= issue_funct3;
                rob_q[tail]          <= issue_rob_pos;
                rs1_pos_q[tail]      <= issue_rs1_tag[ROB_W-1:0];
                rs2_pos_q[tail]      <= issue_rs2_tag[ROB_W-1:0];
                imm_q[tail]          <= issue_imm;
                {rs1_pend_q[tail], rs1_val_q[tail]} <= snoop(issue_rs1_tag[ROB_W], issue_rs1_tag[ROB_W-1:0], issue_rs1_val);
                {rs2_pend_q[tail], rs2_val_q[tail]} <= snoop(issue_rs2_tag[ROB_W], issue_rs2_tag[ROB_W-1:0], issue_rs2_val);
                tail                 <= tail + PW'(1);
            end
        end
    end

    // Memory request registers and the one-cycle load result pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            mc.mc_en       <= 1'b0;
            mc.mc_wr       <= 1'b0;
            mc.mc_addr     <= '0;
            mc.mc_len      <= '0;
            mc.mc_w_data   <= '0;
            result_valid   <= 1'b0;
            result_rob_pos <= '0;
            result_val     <= '0;
        end else if (rdy) begin
            result_valid <= load_result;
            if (launch) begin
                mc.mc_en     <= 1'b1;
                mc.mc_wr     <= head_is_store;
                mc.mc_addr   <= head_addr;
                mc.mc_w_data <= rs2_val_q[head];
                case (funct3_q[head][1:0])
                    2'd0:    mc.mc_len <= 3'd1;
                    2'd1:    mc.mc_len <= 3'd2;
                    default: mc.mc_len <= 3'd4;
                endcase
            end else if (state != S_IDLE && mc.mc_done) begin
                mc.mc_en <= 1'b0;
            end
            if (load_result) begin
                result_rob_pos <= rob_q[head];
                result_val     <= load_ext(funct3_q[head], mc.mc_r_data);
            end
        end
    end

`ifdef LSB_PARAM_STAT_EN
    // Saturating activity counters; orphaned loads never pop so they are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_stall  <= '0;
        end else if (rdy) begin
            if (pop && !head_is_store && stat_loads != '1)  stat_loads  <= stat_loads + 32'd1;
            if (pop && head_is_store && stat_stores != '1)  stat_stores <= stat_stores + 32'd1;
            if (count != '0 && state == S_IDLE && !head_ready && stat_stall != '1)
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: doc/lsb_param.md
Name: lsb_param

Overview:
- Parametrised in-order load/store buffer; successor to the fixed 16-entry LSB.
- Sits between issue/decoder, ROB, and memory controller; snoops two CDB result ports for operand wakeup.
- Executes the head entry only: loads speculatively (MMIO loads only when at ROB head), stores only after ROB commit.
- Broadcasts load results; rollback preserves committed-but-unwritten stores.

Parameters:
DEPTH, 16, entry count; power of two, >=2
ROB_W, 4, ROB index width; operand tags are ROB_W+1 bits, MSB=1 means pending
IO_MASK_HI, 2'b11, value of addr[17:16] that marks MMIO

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; when 0, all state holds
rollback  in  1  flush speculative entries
issue_valid  in  1  enqueue one entry this cycle
issue_rob_pos  in  ROB_W  ROB slot of instruction
issue_is_store  in  1  1=store
issue_funct3  in  3  LB/LH/LW/LBU/LHU or SB/SH/SW encoding
issue_rs1_val / issue_rs2_val  in  32  operand values
issue_rs1_tag / issue_rs2_tag  in  ROB_W+1  {pending, rob_pos}
issue_imm  in  32  address offset
cdb0_valid, cdb1_valid  in  1  result broadcast strobes
cdb0_rob_pos, cdb1_rob_pos  in  ROB_W  producer slot
cdb0_val, cdb1_val  in  32  producer value
commit_store  in  1  ROB commits a store
commit_rob_pos  in  ROB_W  committed store's slot
head_rob_pos  in  ROB_W  current ROB head (MMIO gating)
mc_en  out  1  memory request active
mc_wr  out  1  1=write
mc_addr  out  32  byte address
mc_len  out  3  1/2/4 bytes
mc_w_data  out  32  store data (low bytes)
mc_done  in  1  request complete (one-cycle pulse)
mc_r_data  in  32  load data, zero-extended by controller
result_valid  out  1  load result pulse
result_rob_pos  out  ROB_W  load's ROB slot
result_val  out  32  extended load value
nxt_full  out  1  queue will hold DEPTH entries next cycle
count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset: head=tail=0, count=0, committed_cnt=0, FSM=IDLE; mc_en=mc_wr=0, mc_addr=mc_w_data=0, mc_len=0; result_valid=0, result_rob_pos=0, result_val=0; all entry valid/committed bits 0.
- Enqueue: issue_valid writes the tail entry and increments tail modulo DEPTH.
  - Issue while full is illegal (upstream honours nxt_full); it is ignored, count unchanged.
- Wakeup, every cycle for every valid entry: a pending tag matching a CDB pos takes that value and clears pending.
  - Both ports may hit the same entry; cdb1 wins on a same-tag conflict.
  - Same-cycle issue is also snooped: an issue tag matching a live CDB is captured as ready.
- Commit: commit_store sets committed on the unique valid, uncommitted store whose rob_pos matches; committed_cnt++.
- Head address: addr = rs1_val + imm, mod 2^32. MMIO when addr[17:16] == IO_MASK_HI.
- Head ready:
  - Common: count>0, both operands not pending, no rollback.
  - Load: (!MMIO or rob_pos == head_rob_pos).
  - Store: committed.
- FSM IDLE:
  - Head ready -> next cycle mc_en=1, mc_addr, mc_len (funct3[1:0]: 0->1, 1->2, 2->4), mc_wr=is_store, mc_w_data=rs2_val; go to WAIT.
- FSM WAIT: mc_en and mc_* held stable until mc_done.
  - On mc_done: mc_en=0, head++, count--, go to IDLE (earliest re-issue is the next cycle).
  - Store: committed_cnt--.
  - Load: result_valid=1 next cycle; result_val extended per funct3 (LB/LH sign-, LBU/LHU zero-extend); result_valid pulses for exactly one cycle.
- Simultaneous issue + pop: count unchanged. nxt_full = (count + issue − pop == DEPTH).
- Rollback (ignores issue/commit/CDB that cycle):
  - Drop every uncommitted entry; tail = head + committed_cnt; count = committed_cnt.
  - Committed stores are a head-aligned prefix (in-order commit) and are never lost.
  - If WAIT holds a store: it continues, and mc_done still pops it.
  - If WAIT holds a load: the request is held to mc_done, then discarded with no result_valid and no pop (entry already dropped); FSM marks it "orphan".
  - result_valid is forced 0 in the rollback cycle.
- rdy=0 freezes everything, including mc_en; an mc_done arriving while rdy=0 is unsupported.
- Wrap-around: head/tail pointers are $clog2(DEPTH) bits and wrap naturally; full/empty come from count, never from pointer compare.

Optional Feature:
- Macro LSB_PARAM_STAT_EN.
- Defined: adds outputs stat_loads, stat_stores, stat_stall (32 bits each, reset 0, saturating).
  - stat_loads/stat_stores increment on each load/store mc_done pop; orphan loads are not counted.
  - stat_stall increments each cycle with count>0, FSM=IDLE and head not ready.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- DEPTH=4: issue LW, rs1 ready=0x100, imm=4 -> mc_addr=0x104, mc_len=4; mc_done with mc_r_data=0xDEADBEEF -> result_valid one cycle, result_val=0xDEADBEEF, correct rob_pos.
- LB/LBU with mc_r_data=0x80 -> result_val 0xFFFFFF80 / 0x00000080; LH with 0x8001 -> 0xFFFF8001.
- SW, rs2 tag pending on ROB 3, addr ready -> no mc_en; cdb1 rob 3 val 0x55 -> still no mc_en; commit_store pos matches -> mc_wr=1, mc_w_data=0x55.
- MMIO load at 0x30000 -> no mc_en until head_rob_pos equals entry rob_pos, then request next cycle.
- Fill DEPTH=4 with 4 issues -> nxt_full asserted on the 4th issue cycle; pop+issue same cycle -> count stays 4; pointers wrap after 5+ entries.
- Committed SW then 2 loads, rollback while SW in WAIT -> count=1, SW completes on mc_done, no result_valid; rollback during load WAIT -> load discarded, no result_valid, queue empty.
